// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit frame engine:
// Gray-coded FSM states, parity type codes and counter sizing.
package uart_pkg;

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_START  = 3'b001;
    localparam logic [2:0] S_DATA   = 3'b011;
    localparam logic [2:0] S_PARITY = 3'b010;
    localparam logic [2:0] S_STOP1  = 3'b110;
    localparam logic [2:0] S_STOP2  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP1  = S_STOP1,
        ST_STOP2  = S_STOP2
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter for the UART data phase.
// Ports: CLK, RST (async low), load, ser_en, P_DATA -> ser_data, ser_done.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  ser_en,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int unsigned CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [CW-1:0]         cnt;

    // The bit on the line is always at the outgoing end of shreg.
    if (MSB_FIRST != 0) begin : g_msb
        assign ser_data = shreg[DATA_WIDTH-1];
        assign shifted  = {shreg[DATA_WIDTH-2:0], 1'b0};
    end else begin : g_lsb
        assign ser_data = shreg[0];
        assign shifted  = {1'b0, shreg[DATA_WIDTH-1:1]};
    end

    assign ser_done = (cnt == LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= P_DATA;
            cnt   <= '0;
        end else if (ser_en) begin
            shreg <= shifted;
            // Saturate on the last bit so the count never wraps in a frame.
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame engine: start, data, optional parity, 1/2 stops.
// Ports: CLK, RST, P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2 -> TX_OUT, busy, done.
module uart_tx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  done
);

    state_e state_q;
    state_e state_d;

    logic par_q;
    logic par_en_q;
    logic stop2_q;
    logic tx_q;
    logic busy_q;
    logic done_q;
    logic tx_d;
    logic busy_d;
    logic done_d;
    logic last_stop;
    logic accept;
    logic ser_en;
    logic ser_data;
    logic ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (accept),
        .ser_en   (ser_en),
        .P_DATA   (P_DATA),
        .ser_data (ser_data),
        .ser_done (ser_done)
    );

    assign last_stop = (state_q == ST_STOP2) ||
                       ((state_q == ST_STOP1) && !stop2_q);
    assign accept    = Data_Valid &&
                       ((state_q == ST_IDLE) || last_stop);

    // Line values are decided from the current state and registered,
    // so TX_OUT/busy/done trail the state register by one cycle.
    always_comb begin
        state_d = state_q;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ser_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_d   = ser_data;
                busy_d = 1'b1;
                ser_en = 1'b1;
                if (ser_done) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                tx_d    = par_q;
                busy_d  = 1'b1;
                state_d = ST_STOP1;
            end
            ST_STOP1: begin
                busy_d = 1'b1;
                if (stop2_q) begin
                    state_d = ST_STOP2;
                end else begin
                    done_d  = 1'b1;
                    state_d = accept ? ST_START : ST_IDLE;
                end
            end
            ST_STOP2: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = accept ? ST_START : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (accept) begin
                par_en_q <= PAR_EN;
                stop2_q  <= STOP2;
                par_q    <= (PAR_TYP == PAR_EVEN) ? ^P_DATA : ~^P_DATA;
            end
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl (DATA_WIDTH=8, LSB first).
// Directed frame table, hand sequences and a randomized run against a bit-queue model.
module tb_uart_tx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;
    logic       TX_OUT;
    logic       busy;
    logic       done;

    always #5 CLK = ~CLK;

    uart_tx_frame_ctrl #(
        .DATA_WIDTH (8),
        .MSB_FIRST  (0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic tx;
        logic bsy;
        logic dn;
    } rec_t;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic       s2;
        string      bits;
    } vec_t;

    // Model: queue of line cycles still to be shown for accepted frames.
    rec_t  sq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    acc_cnt = 0;
    string cap;
    int    done_at[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic chk_str(input string n, input string a, input string e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %s expected %s", n, a, e);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pe,
                              input logic pt, input logic s2);
        int   ones;
        logic pb;
        ones = 0;
        sq.push_back('{1'b0, 1'b1, 1'b0});
        for (int i = 0; i < 8; i++) begin
            sq.push_back('{d[i], 1'b1, 1'b0});
            ones += int'(d[i]);
        end
        pb = logic'(ones % 2) ^ pt;
        if (pe) sq.push_back('{pb, 1'b1, 1'b0});
        if (s2) sq.push_back('{1'b1, 1'b1, 1'b0});
        sq.push_back('{1'b1, 1'b1, 1'b1});
    endtask

    task automatic step();
        rec_t       cur;
        logic       acc;
        logic [7:0] d;
        logic       pe, pt, s2;
        cur = '{1'b1, 1'b0, 1'b0};
        if (sq.size() > 0) cur = sq[0];
        // A new frame is taken when idle or on the final queued cycle.
        acc = Data_Valid && (sq.size() <= 1);
        d  = P_DATA;
        pe = PAR_EN;
        pt = PAR_TYP;
        s2 = STOP2;
        @(posedge CLK);
        #1;
        cyc++;
        if (sq.size() > 0) void'(sq.pop_front());
        if (acc) begin
            push_frame(d, pe, pt, s2);
            acc_cnt++;
        end
        chk("tx", {31'd0, TX_OUT}, {31'd0, cur.tx});
        chk("busy", {31'd0, busy}, {31'd0, cur.bsy});
        chk("done", {31'd0, done}, {31'd0, cur.dn});
        if (busy === 1'b1) begin
            if (TX_OUT === 1'b1) cap = {cap, "1"};
            else cap = {cap, "0"};
        end
        if (done === 1'b1) done_at.push_back(cyc);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        sq.delete();
        chk("rst_tx", {31'd0, TX_OUT}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    task automatic go_idle();
        int n;
        n = 0;
        Data_Valid = 1'b0;
        while (sq.size() > 0 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic clear_log();
        cap = "";
        done_at.delete();
    endtask

    vec_t tv[5];
    int   k0;

    initial begin
        tv[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, "0101001011"};
        tv[1] = '{8'h07, 1'b1, 1'b0, 1'b0, "01110000011"};
        tv[2] = '{8'h07, 1'b1, 1'b1, 1'b0, "01110000001"};
        tv[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, "011111111011"};
        tv[4] = '{8'h80, 1'b0, 1'b0, 1'b1, "00000000111"};

        do_reset();
        repeat (3) step();

        foreach (tv[i]) begin
            go_idle();
            clear_log();
            P_DATA = tv[i].d;
            PAR_EN = tv[i].pe;
            PAR_TYP = tv[i].pt;
            STOP2 = tv[i].s2;
            Data_Valid = 1'b1;
            step();
            k0 = cyc;
            Data_Valid = 1'b0;
            repeat (tv[i].bits.len() + 2) step();
            chk_str($sformatf("frame%0d_bits", i), cap, tv[i].bits);
            chk($sformatf("frame%0d_busy_len", i), cap.len(), tv[i].bits.len());
            chk($sformatf("frame%0d_done_cnt", i), done_at.size(), 1);
            if (done_at.size() == 1)
                chk($sformatf("frame%0d_done_pos", i), done_at[0] - k0, tv[i].bits.len());
        end

        // Back-to-back frames with Data_Valid held high.
        go_idle();
        clear_log();
        acc_cnt = 0;
        PAR_EN = 1'b0;
        STOP2 = 1'b0;
        P_DATA = 8'h55;
        Data_Valid = 1'b1;
        for (int n = 0; n < 30 && acc_cnt < 2; n++) begin
            step();
            if (acc_cnt == 1) P_DATA = 8'h33;
        end
        Data_Valid = 1'b0;
        chk("b2b_accepts", acc_cnt, 2);
        repeat (14) step();
        chk_str("b2b_bits", cap, "01010101010110011001");
        chk("b2b_done_cnt", done_at.size(), 2);
        if (done_at.size() == 2)
            chk("b2b_done_gap", done_at[1] - done_at[0], 10);

        // Data_Valid during DATA is ignored, P_DATA changes have no effect.
        go_idle();
        clear_log();
        acc_cnt = 0;
        P_DATA = 8'hA5;
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        repeat (3) step();
        P_DATA = 8'h3C;
        PAR_EN = 1'b1;
        STOP2 = 1'b1;
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        P_DATA = 8'hFF;
        repeat (12) step();
        chk_str("ignore_bits", cap, "0101001011");
        chk("ignore_done_cnt", done_at.size(), 1);
        chk("ignore_accepts", acc_cnt, 1);

        // Reset during data bit 4, then recovery.
        go_idle();
        clear_log();
        PAR_EN = 1'b0;
        STOP2 = 1'b0;
        P_DATA = 8'hA5;
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        repeat (6) step();
        chk("bit4_busy", {31'd0, busy}, 32'd1);
        do_reset();
        repeat (5) step();
        chk("post_rst_tx", {31'd0, TX_OUT}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        clear_log();
        P_DATA = 8'hC3;
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        repeat (12) step();
        chk_str("recover_bits", cap, "0110000111");

        // Randomized traffic with mid-frame config changes and rare resets.
        for (int n = 0; n < 600; n++) begin
            Data_Valid = ($urandom_range(0, 3) == 0);
            P_DATA = 8'($urandom);
            PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom);
            STOP2 = 1'($urandom);
            if ($urandom_range(0, 149) == 0) do_reset();
            else step();
        end
        go_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
